router_fifo: RTL

- One of three per-port output FIFOs in the 1x3 router.
- Sits directly downstream of the synchronizer:
  - takes one write_enb bit from it;
  - returns full/empty to it;
  - obeys the soft_reset timeout it generates.
- Stores packet bytes tagged with a header marker.
- Tracks the packet length on the read side so the destination reads exactly one packet: header, payload, then parity.

---
 rtl/router_fifo_if.sv | 23 ++
 rtl/router_fifo.sv | 98 +++++++++
 2 files changed

// File: rtl/router_fifo_if.sv
// Handshake bundle between the synchronizer/destination side and one router output FIFO.
interface router_fifo_if #(
   parameter int WIDTH = 8
);
   logic             soft_reset;
   logic             write_enb;
   logic             read_enb;
   logic             lfd_state;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;

   modport master (
      output soft_reset, write_enb, read_enb, lfd_state, data_in,
      input  data_out, full, empty
   );

   modport slave (
      input  soft_reset, write_enb, read_enb, lfd_state, data_in,
      output data_out, full, empty
   );
endinterface

// File: rtl/router_fifo.sv
// Per-port router output FIFO: stores header-tagged bytes and tracks the remaining
// packet length on the read side so idle cycles blank data_out between packets.
module router_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input logic         clk,
   input logic         rst,
   router_fifo_if.slave bus
);
   localparam int PW  = AW + 1;
   localparam int PCW = WIDTH - 2;

   logic [WIDTH:0]   mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [PCW-1:0]   pkt_count_r;
   logic [WIDTH-1:0] data_out_r;

   logic             full_s;
   logic             empty_s;
   logic             wr_accept_s;
   logic             rd_accept_s;
   logic [WIDTH:0]   rd_word_s;
   logic [PCW-1:0]   pkt_count_nxt_s;
   logic [WIDTH-1:0] data_out_nxt_s;

   // Occupancy flags and accept decisions from the pre-edge pointers
   always_comb begin
      empty_s     = (wr_ptr_r == rd_ptr_r);
      full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      wr_accept_s = bus.write_enb && !full_s;
      rd_accept_s = bus.read_enb && !empty_s;
      rd_word_s   = mem_r[rd_ptr_r[AW-1:0]];
   end

   // Read-side packet length tracking and data_out next value
   always_comb begin
      pkt_count_nxt_s = pkt_count_r;
      data_out_nxt_s  = data_out_r;
      if (rd_accept_s) begin
         data_out_nxt_s = rd_word_s[WIDTH-1:0];
         if (rd_word_s[WIDTH]) begin
            // header carries payload length; +1 accounts for the trailing parity byte
            pkt_count_nxt_s = rd_word_s[WIDTH-1:2] + PCW'(1);
         end else if (pkt_count_r != {PCW{1'b0}}) begin
            pkt_count_nxt_s = pkt_count_r - PCW'(1);
         end else begin
            pkt_count_nxt_s = pkt_count_r;
         end
      end else if (pkt_count_r == {PCW{1'b0}}) begin
         data_out_nxt_s = {WIDTH{1'b0}};
      end else begin
         data_out_nxt_s = data_out_r;
      end
   end

   // Pointer, counter and output register update with reset/flush priority
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         pkt_count_r <= {PCW{1'b0}};
         data_out_r  <= {WIDTH{1'b0}};
      end else if (bus.soft_reset) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         pkt_count_r <= {PCW{1'b0}};
         data_out_r  <= {WIDTH{1'b0}};
      end else begin
         if (wr_accept_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (rd_accept_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         pkt_count_r <= pkt_count_nxt_s;
         data_out_r  <= data_out_nxt_s;
      end
   end

   // Storage array; contents are left as-is on reset since pointers define validity
   always_ff @(posedge clk) begin
      if (!rst && !bus.soft_reset && wr_accept_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {bus.lfd_state, bus.data_in};
      end
   end

   assign bus.full     = full_s;
   assign bus.empty    = empty_s;
   assign bus.data_out = data_out_r;
endmodule
